mux21_arb_ctrl: RTL and testbench

//  Sequencing/arbitration controller for the shared 32-bit 2:1 data mux. Two requesters

---
 rtl/mux21_arb_ctrl_pkg.sv | 8 +
 rtl/mux21_arb_ctrl_mux.sv | 15 +
 rtl/mux21_arb_ctrl.sv | 97 +++++++++
 tb/tb_mux21_arb_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mux21_arb_ctrl_pkg.sv
// mux21_arb_ctrl_pkg: FSM state encodings and default datapath width for the arbitration controller
package mux21_arb_ctrl_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t OWN0 = 2'd1;
  localparam state_t OWN1 = 2'd2;
  localparam int WIDTH_DEF = 32;
endpackage

// File: rtl/mux21_arb_ctrl_mux.sv
// mux21_arb_ctrl_mux: WIDTH-bit 2:1 data mux (i_sel=0 -> i_a, i_sel=1 -> i_b)
//   i_sel  select
//   i_a    input word 0
//   i_b    input word 1
//   o_y    selected word
module mux21_arb_ctrl_mux #(
  parameter int WIDTH = 32
) (
  input  logic             i_sel,
  input  logic [0:WIDTH-1] i_a,
  input  logic [0:WIDTH-1] i_b,
  output logic [0:WIDTH-1] o_y
);
  assign o_y = i_sel ? i_b : i_a;
endmodule

// File: rtl/mux21_arb_ctrl.sv
// mux21_arb_ctrl: round-robin 2-requester arbiter with capped locked bursts driving a shared 2:1 mux into a registered output
//   clk, rst_n                          clock, async active-low reset
//   i_in0_data/valid/lock, o_in0_ready  requester 0 handshake
//   i_in1_data/valid/lock, o_in1_ready  requester 1 handshake
//   o_out_data, o_out_valid, i_out_ready  registered output channel
//   o_sel                               current mux select (granted requester)
//   o_busy                              a requester holds a lock
module mux21_arb_ctrl
  import mux21_arb_ctrl_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [0:WIDTH-1] i_in0_data,
  input  logic             i_in0_valid,
  input  logic             i_in0_lock,
  output logic             o_in0_ready,
  input  logic [0:WIDTH-1] i_in1_data,
  input  logic             i_in1_valid,
  input  logic             i_in1_lock,
  output logic             o_in1_ready,
  output logic [0:WIDTH-1] o_out_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_sel,
  output logic             o_busy
);
  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
  logic               r_last, r_sel, r_out_valid;
  logic [0:WIDTH-1]   r_out_data, w_mux;
  logic               w_load, w_gnt_vld, w_gnt, w_sel, w_xfer, w_lock, w_rel;

  mux21_arb_ctrl_mux #(.WIDTH(WIDTH)) u_mux (
    .i_sel (w_sel),
    .i_a   (i_in0_data),
    .i_b   (i_in1_data),
    .o_y   (w_mux)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // State and counter move only on a transfer beat; a stalled owner keeps its place.
  always_comb begin
    w_cnt_inc   = r_cnt + 1'b1;
    w_rel       = ~w_lock | (w_cnt_inc >= CNT_W'(MAX_BURST));
    w_state_nxt = ~w_xfer ? r_state : w_rel ? IDLE : (w_gnt ? OWN1 : OWN0);
    w_cnt_nxt   = ~w_xfer ? r_cnt : w_rel ? '0 : w_cnt_inc;
  end

  // Grant is suppressed during reset so readys and sel stay quiet while rst_n is low.
  always_comb begin
    w_load      = ~r_out_valid | i_out_ready;
    w_gnt_vld   = rst_n & ((r_state != IDLE) | i_in0_valid | i_in1_valid);
    w_gnt       = (r_state == OWN1) ? 1'b1 :
                  (r_state == OWN0) ? 1'b0 :
                  (i_in0_valid & i_in1_valid) ? ~r_last : i_in1_valid;
    w_sel       = w_gnt_vld ? w_gnt : r_sel;
    w_lock      = w_gnt ? i_in1_lock : i_in0_lock;
    w_xfer      = w_load & w_gnt_vld & (w_gnt ? i_in1_valid : i_in0_valid);
    o_in0_ready = w_load & w_gnt_vld & ~w_gnt;
    o_in1_ready = w_load & w_gnt_vld & w_gnt;
    o_sel       = w_sel;
    o_busy      = r_state != IDLE;
    o_out_data  = r_out_data;
    o_out_valid = r_out_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_last      <= 1'b1;
      r_sel       <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_out_data  <= w_mux;
        r_out_valid <= 1'b1;
        r_last      <= w_gnt;
      end else if (w_load & i_out_ready) begin
        r_out_valid <= 1'b0;
      end
      r_sel <= w_sel;
    end
  end
endmodule

// File: tb/tb_mux21_arb_ctrl.sv
// tb_mux21_arb_ctrl: directed vector table plus hand sequences for stall and mid-burst reset
module tb_mux21_arb_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:31] in0_data, in1_data, out_data;
  logic        in0_valid, in0_lock, in0_ready;
  logic        in1_valid, in1_lock, in1_ready;
  logic        out_valid, out_ready, sel, busy;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  mux21_arb_ctrl #(.WIDTH(32), .MAX_BURST(4), .CNT_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in0_data  (in0_data),
    .i_in0_valid (in0_valid),
    .i_in0_lock  (in0_lock),
    .o_in0_ready (in0_ready),
    .i_in1_data  (in1_data),
    .i_in1_valid (in1_valid),
    .i_in1_lock  (in1_lock),
    .o_in1_ready (in1_ready),
    .o_out_data  (out_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_sel       (sel),
    .o_busy      (busy)
  );

  typedef struct {
    logic        v0, l0, v1, l1, ordy;
    logic [31:0] d0, d1;
    logic        r0, r1, s;
    logic        ov;
    logic [31:0] od;
    logic        bz;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic v0, l0, input logic [31:0] d0,
                              input logic v1, l1, input logic [31:0] d1, input logic ordy,
                              input logic r0, r1, s, ov, input logic [31:0] od, input logic bz);
    vec_t v;
    v.v0 = v0; v.l0 = l0; v.d0 = d0; v.v1 = v1; v.l1 = l1; v.d1 = d1; v.ordy = ordy;
    v.r0 = r0; v.r1 = r1; v.s = s; v.ov = ov; v.od = od; v.bz = bz;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v0, l0, input logic [31:0] d0,
                       input logic v1, l1, input logic [31:0] d1, input logic ordy);
    in0_valid = v0; in0_lock = l0; in0_data = d0;
    in1_valid = v1; in1_lock = l1; in1_data = d1;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // contention without lock: alternates, in0 first
    tbl[0]  = mk(1,0,32'hFFFFFFFF, 1,0,32'h00000000, 1,  1,0,0, 1,32'hFFFFFFFF, 0);
    tbl[1]  = mk(1,0,32'hFFFFFFFF, 1,0,32'h00000000, 1,  0,1,1, 1,32'h00000000, 0);
    tbl[2]  = mk(1,0,32'hFFFFFFFF, 1,0,32'h00000000, 1,  1,0,0, 1,32'hFFFFFFFF, 0);
    tbl[3]  = mk(1,0,32'hFFFFFFFF, 1,0,32'h00000000, 1,  0,1,1, 1,32'h00000000, 0);
    // locked burst by in0 capped at four beats, then in1
    tbl[4]  = mk(1,1,32'h11111111, 1,0,32'h22222222, 1,  1,0,0, 1,32'h11111111, 1);
    tbl[5]  = mk(1,1,32'h11111111, 1,0,32'h22222222, 1,  1,0,0, 1,32'h11111111, 1);
    tbl[6]  = mk(1,1,32'h11111111, 1,0,32'h22222222, 1,  1,0,0, 1,32'h11111111, 1);
    tbl[7]  = mk(1,1,32'h11111111, 1,0,32'h22222222, 1,  1,0,0, 1,32'h11111111, 0);
    tbl[8]  = mk(1,1,32'h11111111, 1,0,32'h22222222, 1,  0,1,1, 1,32'h22222222, 0);
    // backpressure: output held, no readys, then the pending word goes through
    tbl[9]  = mk(1,0,32'h33333333, 0,0,32'h0,        0,  0,0,0, 1,32'h22222222, 0);
    tbl[10] = mk(1,0,32'h33333333, 0,0,32'h0,        0,  0,0,0, 1,32'h22222222, 0);
    tbl[11] = mk(1,0,32'h33333333, 0,0,32'h0,        0,  0,0,0, 1,32'h22222222, 0);
    tbl[12] = mk(1,0,32'h33333333, 0,0,32'h0,        1,  1,0,0, 1,32'h33333333, 0);
    // drain to empty, then sel holds after an in1 grant disappears
    tbl[13] = mk(0,0,32'h0,        0,0,32'h0,        1,  0,0,0, 0,32'h33333333, 0);
    tbl[14] = mk(0,0,32'h0,        1,0,32'h44444444, 1,  0,1,1, 1,32'h44444444, 0);
    tbl[15] = mk(0,0,32'h0,        0,0,32'h0,        1,  0,0,1, 0,32'h44444444, 0);

    rst_n = 1'b0;
    drive(1,0,32'hAAAAAAAA, 1,0,32'h55555555, 1);
    #12;
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst out_data", out_data, 32'd0);
    chk("rst in0_ready", {31'd0, in0_ready}, 32'd0);
    chk("rst in1_ready", {31'd0, in1_ready}, 32'd0);
    chk("rst sel", {31'd0, sel}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    drive(0,0,32'h0, 0,0,32'h0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].v0, tbl[i].l0, tbl[i].d0, tbl[i].v1, tbl[i].l1, tbl[i].d1, tbl[i].ordy);
      #1;
      chk($sformatf("v%0d in0_ready", i), {31'd0, in0_ready}, {31'd0, tbl[i].r0});
      chk($sformatf("v%0d in1_ready", i), {31'd0, in1_ready}, {31'd0, tbl[i].r1});
      chk($sformatf("v%0d sel", i), {31'd0, sel}, {31'd0, tbl[i].s});
      tick();
      chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ov});
      chk($sformatf("v%0d out_data", i), out_data, tbl[i].od);
      chk($sformatf("v%0d busy", i), {31'd0, busy}, {31'd0, tbl[i].bz});
    end

    // owner stall: in1 locks, pauses two cycles while in0 waits, then continues its count
    drive(0,0,32'h0, 1,1,32'h55555555, 1);
    #1;
    chk("own1 in1_ready", {31'd0, in1_ready}, 32'd1);
    tick();
    chk("own1 busy", {31'd0, busy}, 32'd1);
    chk("own1 data", out_data, 32'h55555555);
    drive(1,0,32'h66666666, 0,1,32'h0, 1);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("stall%0d in0_ready", i), {31'd0, in0_ready}, 32'd0);
      chk($sformatf("stall%0d sel", i), {31'd0, sel}, 32'd1);
      tick();
      chk($sformatf("stall%0d busy", i), {31'd0, busy}, 32'd1);
      chk($sformatf("stall%0d out_valid", i), {31'd0, out_valid}, 32'd0);
    end
    drive(1,0,32'h66666666, 1,1,32'h77777777, 1);
    #1;
    chk("resume in1_ready", {31'd0, in1_ready}, 32'd1);
    chk("resume in0_ready", {31'd0, in0_ready}, 32'd0);
    tick();
    chk("resume data", out_data, 32'h77777777);
    chk("beat2 busy", {31'd0, busy}, 32'd1);
    tick();
    chk("beat3 busy", {31'd0, busy}, 32'd1);
    tick();
    chk("beat4 release", {31'd0, busy}, 32'd0);
    drive(1,0,32'h66666666, 1,0,32'h77777777, 1);
    #1;
    chk("post-release in0_ready", {31'd0, in0_ready}, 32'd1);
    chk("post-release in1_ready", {31'd0, in1_ready}, 32'd0);
    tick();
    chk("post-release data", out_data, 32'h66666666);

    // reset during beat 2 of an in0 burst: everything clears, in0 wins again
    drive(1,1,32'h88888888, 0,0,32'h99999999, 1);
    tick();
    tick();
    chk("burst busy", {31'd0, busy}, 32'd1);
    in1_valid = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst out_data", out_data, 32'd0);
    chk("midrst sel", {31'd0, sel}, 32'd0);
    chk("midrst in0_ready", {31'd0, in0_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in0_lock = 1'b0;
    #1;
    chk("after rst in0_ready", {31'd0, in0_ready}, 32'd1);
    chk("after rst in1_ready", {31'd0, in1_ready}, 32'd0);
    tick();
    chk("after rst data", out_data, 32'h88888888);
    chk("after rst busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
